// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encoding,
// per-stage control payload and the opcode-to-carry-in helper.
package pipe_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Control fields that travel with an operation from stage to stage.
  typedef struct packed {
    logic vld;
    logic sub;
  } stage_ctl_t;

  // Subtraction is A + ~B + 1, so the opcode itself is the stage-0 carry-in.
  function automatic logic op_cin(input logic sub);
    return (sub == OP_SUB);
  endfunction

endpackage

// File: rtl/pipe_addsub_if.sv
// Operand/result handshake bundle of pipe_addsub: operands in with valid/ready,
// result with sum, raw carry, signed overflow and zero flags out with valid/ready.
interface pipe_addsub_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/pipe_addsub_seg.sv
// addsub_seg: one SEG-bit slice of the split carry chain; adds a, b and cin and
// registers the slice sum together with its carry-out when en is high.
module addsub_seg
  import pipe_addsub_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (en) begin
      sum  <= total[SEG-1:0];
      cout <= total[SEG];
    end
  end

endmodule

// File: rtl/pipe_addsub.sv
// pipe_addsub: WIDTH-bit add/subtract with the carry chain cut into STAGES registered
// segments, valid/ready on both sides. Define PIPE_ADDSUB_SAT_EN to saturate on overflow.
module pipe_addsub
  import pipe_addsub_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input logic          clk,
  input logic          rst_n,
  pipe_addsub_if.slave bus
);

  localparam int SEG = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_cfg_check
    $fatal(1, "pipe_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  // Stage registers: ctl/a/b per stage; s_p holds the segments finished by earlier stages.
  stage_ctl_t       ctl_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] s_p   [STAGES];

  stage_ctl_t       ctl_in [STAGES];
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic [STAGES-1:0] cin_in;

  logic [SEG-1:0]   seg_sum [STAGES];
  logic [STAGES-1:0] seg_cout;
  logic [WIDTH-1:0] sum_w   [STAGES];

  logic [STAGES-1:0] en;
  logic [STAGES-1:0] ld;
  logic              nxt;

  logic [WIDTH-1:0] res_sum;
  logic             res_ovf;
  logic             a_msb;
  logic             b_eff_msb;

  // Advance chain: a stage may load when it is empty or its content moves on.
  always_comb begin
    nxt = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !ctl_p[k].vld || nxt;
      nxt   = en[k];
    end
  end

  always_comb begin
    ctl_in[0] = '{vld: bus.in_valid, sub: bus.in_sub};
    a_in[0]   = bus.in_a;
    b_in[0]   = bus.in_b;
    s_in[0]   = '0;
    cin_in[0] = op_cin(bus.in_sub);
    for (int k = 1; k < STAGES; k++) begin
      ctl_in[k] = ctl_p[k-1];
      a_in[k]   = a_p[k-1];
      b_in[k]   = b_p[k-1];
      s_in[k]   = sum_w[k-1];
      cin_in[k] = seg_cout[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      ld[k] = en[k] && ctl_in[k].vld;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    logic [SEG-1:0] b_eff;

    assign b_eff = b_in[k][k*SEG +: SEG] ^ {SEG{ctl_in[k].sub == OP_SUB}};

    addsub_seg #(
      .SEG (SEG)
    ) u_seg (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (ld[k]),
      .a    (a_in[k][k*SEG +: SEG]),
      .b    (b_eff),
      .cin  (cin_in[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k])
    );
  end

  // Segments above k are still zero in s_p[k], so OR merges stage k's slice in place.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_w[k] = s_p[k] | (WIDTH'(seg_sum[k]) << (k * SEG));
    end
  end

  // ---- stage registers p0 .. p(STAGES-1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_p[k] <= '0;
        a_p[k]   <= '0;
        b_p[k]   <= '0;
        s_p[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) ctl_p[k] <= ctl_in[k];
        if (ld[k]) begin
          a_p[k] <= a_in[k];
          b_p[k] <= b_in[k];
          s_p[k] <= s_in[k];
        end
      end
    end
  end

`ifdef PIPE_ADDSUB_SAT_EN
  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] s,
                                                input logic a_neg,
                                                input logic ovf);
    logic [WIDTH-1:0] smin;
    smin      = '0;
    smin[MSB] = 1'b1;
    if (!ovf) return s;
    return a_neg ? smin : ~smin;
  endfunction
`endif

  // ---- output stage: flags from the last stage registers
  always_comb begin
    a_msb     = a_p[STAGES-1][MSB];
    b_eff_msb = b_p[STAGES-1][MSB] ^ (ctl_p[STAGES-1].sub == OP_SUB);
    res_sum   = sum_w[STAGES-1];
    res_ovf   = (a_msb == b_eff_msb) && (res_sum[MSB] != a_msb);
`ifdef PIPE_ADDSUB_SAT_EN
    res_sum   = saturate(res_sum, a_msb, res_ovf);
`endif
  end

  // Outputs are forced to zero whenever no result is presented.
  assign bus.in_ready  = en[0];
  assign bus.out_valid = ctl_p[STAGES-1].vld;
  assign bus.out_sum   = ctl_p[STAGES-1].vld ? res_sum : '0;
  assign bus.out_cout  = ctl_p[STAGES-1].vld && seg_cout[STAGES-1];
  assign bus.out_ovf   = ctl_p[STAGES-1].vld && res_ovf;
  assign bus.out_zero  = ctl_p[STAGES-1].vld && (res_sum == '0);

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: main instance at STAGES=2 plus STAGES=1,4,32 instances
// sharing stimulus, all checked against an arithmetic reference model.
module tb_pipe_addsub;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         v = 1'b0;
  logic         s = 1'b0;
  logic         rdy = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  int           total = 0;
  int           bad = 0;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  always #5 clk = ~clk;

  pipe_addsub_if #(.WIDTH(W)) bus1(), bus2(), bus4(), bus32();

  assign bus1.in_valid  = v;   assign bus1.in_a  = a; assign bus1.in_b  = b;
  assign bus1.in_sub    = s;   assign bus1.out_ready  = rdy;
  assign bus2.in_valid  = v;   assign bus2.in_a  = a; assign bus2.in_b  = b;
  assign bus2.in_sub    = s;   assign bus2.out_ready  = rdy;
  assign bus4.in_valid  = v;   assign bus4.in_a  = a; assign bus4.in_b  = b;
  assign bus4.in_sub    = s;   assign bus4.out_ready  = rdy;
  assign bus32.in_valid = v;   assign bus32.in_a = a; assign bus32.in_b = b;
  assign bus32.in_sub   = s;   assign bus32.out_ready = rdy;

  pipe_addsub #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  pipe_addsub #(.WIDTH(W), .STAGES(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  pipe_addsub #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  pipe_addsub #(.WIDTH(W), .STAGES(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

  // Reference: exact signed/unsigned arithmetic in 64 bits, then wrap to W.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
    res_t   r;
    longint sx, sy, sr, smax, smin;
    smax  = (longint'(1) << (W - 1)) - 1;
    smin  = -(longint'(1) << (W - 1));
    sx    = longint'($signed(x));
    sy    = longint'($signed(y));
    sr    = sub ? (sx - sy) : (sx + sy);
    r.ovf = (sr > smax) || (sr < smin);
    r.sum = sr[W-1:0];
    if (sub) r.cout = (x >= y);
    else     r.cout = ((longint'(x) + longint'(y)) >= (longint'(1) << W));
`ifdef PIPE_ADDSUB_SAT_EN
    if (r.ovf) r.sum = x[W-1] ? smin[W-1:0] : smax[W-1:0];
`endif
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0:       return '0;
      1:       return '1;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h0000_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic res_t grab(input int i);
    case (i)
      0:       return {bus1.out_sum,  bus1.out_cout,  bus1.out_ovf,  bus1.out_zero};
      1:       return {bus4.out_sum,  bus4.out_cout,  bus4.out_ovf,  bus4.out_zero};
      default: return {bus32.out_sum, bus32.out_cout, bus32.out_ovf, bus32.out_zero};
    endcase
  endfunction

  function automatic logic vgrab(input int i);
    case (i)
      0:       return bus1.out_valid;
      1:       return bus4.out_valid;
      default: return bus32.out_valid;
    endcase
  endfunction

  function automatic logic rgrab(input int i);
    case (i)
      0:       return bus1.in_ready;
      1:       return bus4.in_ready;
      default: return bus32.in_ready;
    endcase
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; v = 1'b0; rdy = 1'b1; a = '0; b = '0; s = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({bus2.out_valid, bus2.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL reset_ctl got valid,ready=%b want=01", {bus2.out_valid, bus2.in_ready});
    end
    total++;
    if ({bus2.out_sum, bus2.out_cout, bus2.out_ovf, bus2.out_zero} !== '0) begin
      bad++;
      $display("FAIL reset_data got sum=%h c=%b o=%b z=%b want all 0",
               bus2.out_sum, bus2.out_cout, bus2.out_ovf, bus2.out_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [8] = '{32'h1, 32'hFFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                             32'h5, 32'h7, 32'h8000_0000, 32'h0};
    logic [W-1:0] tb [8] = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h7, 32'h5, 32'h1, 32'h0};
    logic         ts [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    res_t e, g;
    int   lat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      v = 1'b1; a = ta[i]; b = tb[i]; s = ts[i]; rdy = 1'b1;
      e = model(ta[i], tb[i], ts[i]);
      @(negedge clk);
      v = 1'b0;
      lat = 1;
      while (!bus2.out_valid && lat < 8) begin
        @(negedge clk);
        lat++;
      end
      total++;
      if (lat != 2) begin
        bad++;
        $display("FAIL dir_latency[%0d] got=%0d want=2", i, lat);
      end
      g = {bus2.out_sum, bus2.out_cout, bus2.out_ovf, bus2.out_zero};
      total++;
      if (g !== e) begin
        bad++;
        $display("FAIL dir_result[%0d] got sum=%h c=%b o=%b z=%b want sum=%h c=%b o=%b z=%b",
                 i, g.sum, g.cout, g.ovf, g.zero, e.sum, e.cout, e.ovf, e.zero);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t e, g;
    int   sent = 0, rcvd = 0;
    bit   blocked = 0, pend = 0;
    for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
      @(negedge clk);
      rdy = !(cyc >= 3 && cyc <= 5);
      if (!pend && sent < 8) begin
        a = $urandom(); b = $urandom(); s = 1'($urandom_range(0, 1)); pend = 1;
      end
      v = pend;
      #1;
      if (v && !bus2.in_ready) blocked = 1;
      if (bus2.out_valid && rdy) begin
        g = {bus2.out_sum, bus2.out_cout, bus2.out_ovf, bus2.out_zero};
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL b2b_extra got sum=%h want=no output", g.sum);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL b2b_result[%0d] got=%h want=%h", rcvd, g, e);
          end
        end
        rcvd++;
      end
      if (v && bus2.in_ready) begin
        q.push_back(model(a, b, s));
        sent++;
        pend = 0;
      end
    end
    v = 1'b0; rdy = 1'b1;
    total++;
    if (!blocked) begin
      bad++;
      $display("FAIL b2b_backpressure got in_ready never low want low while full");
    end
    total++;
    if (rcvd != 8 || q.size() != 0) begin
      bad++;
      $display("FAIL b2b_count got rcvd=%0d left=%0d want rcvd=8 left=0", rcvd, q.size());
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t e, g, held;
    bit   pend = 0, stalled = 0;
    int   sent = 0, rcvd = 0;
    for (int cyc = 0; cyc < 260; cyc++) begin
      @(negedge clk);
      g = {bus2.out_sum, bus2.out_cout, bus2.out_ovf, bus2.out_zero};
      if (stalled) begin
        total++;
        if (!bus2.out_valid || g !== held) begin
          bad++;
          $display("FAIL stall_hold got v=%b %h want v=1 %h", bus2.out_valid, g, held);
        end
      end
      rdy = (cyc >= 220) || ($urandom_range(0, 3) != 0);
      if (!pend && cyc < 200 && $urandom_range(0, 9) < 7) begin
        a = pick(); b = pick(); s = 1'($urandom_range(0, 1)); pend = 1;
      end
      v = pend;
      #1;
      stalled = bus2.out_valid && !rdy;
      held    = g;
      if (bus2.out_valid && rdy) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rnd_extra got sum=%h want=no output", g.sum);
        end else begin
          e = q.pop_front();
          if (g !== e) begin
            bad++;
            $display("FAIL rnd_result[%0d] got=%h want=%h", rcvd, g, e);
          end
        end
        rcvd++;
      end
      if (v && bus2.in_ready) begin
        q.push_back(model(a, b, s));
        sent++;
        pend = 0;
      end
    end
    v = 1'b0; rdy = 1'b1;
    total++;
    if (q.size() != 0 || rcvd != sent) begin
      bad++;
      $display("FAIL rnd_drain got rcvd=%0d sent=%0d left=%0d want all delivered",
               rcvd, sent, q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit stale = 0;
    @(negedge clk);
    rdy = 1'b0; v = 1'b1; a = $urandom(); b = $urandom(); s = 1'b0;
    @(negedge clk);
    a = $urandom(); b = $urandom(); s = 1'b1;
    @(negedge clk);
    v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus2.out_valid, bus2.in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL rstmid_immediate got valid,ready=%b want=01", {bus2.out_valid, bus2.in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; rdy = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus2.out_valid) stale = 1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL rstmid_stale got out_valid=1 after reset want=0");
    end
  endtask

  task automatic test_other_stages();
    res_t qs [3][$];
    int   qc [3][$];
    int   sv [3] = '{1, 4, 32};
    res_t e, g;
    int   lat;
    bit   stale = 0;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 64; cyc++) begin
      @(negedge clk);
      rdy = 1'b1;
      if (cyc < 24) begin
        v = 1'b1; a = pick(); b = pick(); s = 1'($urandom_range(0, 1));
      end else begin
        v = 1'b0;
      end
      #1;
      for (int i = 0; i < 3; i++) begin
        if (vgrab(i)) begin
          total++;
          g = grab(i);
          if (qs[i].size() == 0) begin
            bad++;
            $display("FAIL stg%0d_extra got sum=%h want=no output", sv[i], g.sum);
          end else begin
            e   = qs[i].pop_front();
            lat = cyc - qc[i].pop_front();
            if (g !== e || lat != sv[i]) begin
              bad++;
              $display("FAIL stg%0d_result got=%h lat=%0d want=%h lat=%0d", sv[i], g, lat, e, sv[i]);
            end
          end
        end
        if (v && rgrab(i)) begin
          qs[i].push_back(model(a, b, s));
          qc[i].push_back(cyc);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (qs[i].size() != 0) begin
        bad++;
        $display("FAIL stg%0d_drain got left=%0d want=0", sv[i], qs[i].size());
      end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      v = 1'b1; a = pick(); b = pick(); s = 1'b0;
    end
    @(negedge clk);
    v = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus1.out_valid, bus2.out_valid, bus4.out_valid, bus32.out_valid} !== 4'b0) begin
      bad++;
      $display("FAIL stg_rst_immediate got valids=%b want=0000",
               {bus1.out_valid, bus2.out_valid, bus4.out_valid, bus32.out_valid});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus1.out_valid || bus2.out_valid || bus4.out_valid || bus32.out_valid) stale = 1;
    end
    total++;
    if (stale) begin
      bad++;
      $display("FAIL stg_rst_stale got out_valid=1 after reset want=0");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout want test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_other_stages();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
